// File: rtl/dram_responder_if.sv
// Request/response bundle between a scratchpad backend (master) and a DRAM
// endpoint (slave).
interface dram_responder_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  // A request transfers on a rising edge where req_valid=1 and dram_be_stall=0.
  // A stalled requester holds the request unchanged until it transfers.
  // Responses have no backpressure: res_valid is a single-cycle pulse.
  logic              req_valid;
  logic              req_write;
  logic [ID_W-1:0]   req_id;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_num_bytes;
  logic [DATA_W-1:0] req_wdata;
  logic              stall_inject;
  logic              dram_be_stall;
  logic              res_valid;
  logic [ID_W-1:0]   res_id;
  logic [DATA_W-1:0] res_rdata;

  modport master (
    output req_valid, req_write, req_id, req_addr, req_num_bytes, req_wdata,
    output stall_inject,
    input  dram_be_stall, res_valid, res_id, res_rdata
  );

  modport slave (
    input  req_valid, req_write, req_id, req_addr, req_num_bytes, req_wdata,
    input  stall_inject,
    output dram_be_stall, res_valid, res_id, res_rdata
  );
endinterface

// File: rtl/dram_responder.sv
// DRAM stand-in: word-addressed backing array with byte-masked writes and
// fixed-latency, in-order read responses through a bounded in-flight queue.
module dram_responder #(
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 4,
  parameter int Q_DEPTH    = 8
) (
  input logic              clk,
  input logic              n_rst,
  dram_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int BYTES = DATA_W / 8;

  localparam logic [LAT_W-1:0] CD_INIT  = LAT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Q_DEPTH);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [ID_W-1:0]   q_id   [Q_DEPTH];
  logic [DATA_W-1:0] q_data [Q_DEPTH];
  logic [LAT_W-1:0]  q_cd   [Q_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              res_valid_q;
  logic [ID_W-1:0]   res_id_q;
  logic [DATA_W-1:0] res_rdata_q;

  logic              stall;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic              do_pop;
  logic [IDX_W-1:0]  widx;
  logic              unused_addr_bits;

  // Stall looks only at the registered count, so a full queue refuses a
  // request even in the cycle its head pops.
  assign stall    = (count == CNT_FULL) || bus.stall_inject;
  assign accept   = bus.req_valid && !stall;
  assign do_write = accept && bus.req_write;
  assign do_read  = accept && !bus.req_write;
  assign do_pop   = (count != '0) && (q_cd[rd_ptr] == '0);
  assign widx     = bus.req_addr[IDX_W+2:3];

  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+3], bus.req_addr[2:0]};

  assign bus.dram_be_stall = stall;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_id        = res_id_q;
  assign bus.res_rdata     = res_rdata_q;

  // Backing array keeps its contents across reset. Byte lanes at or above
  // req_num_bytes keep their old value; counts above BYTES saturate naturally.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (do_write && (b < int'(bus.req_num_bytes))) begin
        mem[widx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  // Queue payload and countdowns. Slots outside [rd_ptr, wr_ptr) are stale
  // and are always rewritten by a push before they can become the head.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (q_cd[i] != '0) begin
        q_cd[i] <= q_cd[i] - LAT_W'(1);
      end
    end
    if (do_read) begin
      q_id[wr_ptr]   <= bus.req_id;
      q_data[wr_ptr] <= mem[widx];
      q_cd[wr_ptr]   <= CD_INIT;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
    end else begin
      res_valid_q <= do_pop;
      if (do_pop) begin
        res_id_q    <= q_id[rd_ptr];
        res_rdata_q <= q_data[rd_ptr];
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (do_read) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({do_read, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: one instance at RD_LATENCY=4 and one at
// RD_LATENCY=16, sharing clock, reset and request fields.
module tb_dram_responder;
  logic clk;
  logic n_rst;

  // shared request fields, steered to one instance by sel
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [7:0]  req_id;
  logic [31:0] req_addr;
  logic [3:0]  req_num_bytes;
  logic [63:0] req_wdata;
  logic        inj;
  logic        stall_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [71:0] exp4_q[$];
  logic [71:0] exp16_q[$];
  int          res4_cyc_q[$];
  int          res16_cyc_q[$];

  dram_responder_if #(.ID_W(8), .ADDR_W(32), .DATA_W(64)) bus4 ();
  dram_responder_if #(.ID_W(8), .ADDR_W(32), .DATA_W(64)) bus16 ();

  dram_responder #(.ID_W(8), .ADDR_W(32), .DATA_W(64), .MEM_WORDS(1024),
                   .RD_LATENCY(4), .Q_DEPTH(8)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .bus(bus4.slave));

  dram_responder #(.ID_W(8), .ADDR_W(32), .DATA_W(64), .MEM_WORDS(1024),
                   .RD_LATENCY(16), .Q_DEPTH(8)) u_dut16 (
    .clk(clk), .n_rst(n_rst), .bus(bus16.slave));

  assign bus4.req_valid      = req_valid && !sel;
  assign bus4.req_write      = req_write;
  assign bus4.req_id         = req_id;
  assign bus4.req_addr       = req_addr;
  assign bus4.req_num_bytes  = req_num_bytes;
  assign bus4.req_wdata      = req_wdata;
  assign bus4.stall_inject   = inj && !sel;
  assign bus16.req_valid     = req_valid && sel;
  assign bus16.req_write     = req_write;
  assign bus16.req_id        = req_id;
  assign bus16.req_addr      = req_addr;
  assign bus16.req_num_bytes = req_num_bytes;
  assign bus16.req_wdata     = req_wdata;
  assign bus16.stall_inject  = inj && sel;
  assign stall_sel = sel ? bus16.dram_be_stall : bus4.dram_be_stall;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scoreboard: responses must match the expected queue, in order
  always @(negedge clk) begin
    logic [71:0] e;
    if (bus4.res_valid === 1'b1) begin
      res4_cyc_q.push_back(cyc);
      if (exp4_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_res: got id %h, required no response", bus4.res_id);
      end else begin
        e = exp4_q.pop_front();
        check("a_res_id", {56'd0, bus4.res_id}, {56'd0, e[71:64]});
        check("a_res_data", bus4.res_rdata, e[63:0]);
      end
    end
    if (bus16.res_valid === 1'b1) begin
      res16_cyc_q.push_back(cyc);
      if (exp16_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_res: got id %h, required no response", bus16.res_id);
      end else begin
        e = exp16_q.pop_front();
        check("b_res_id", {56'd0, bus16.res_id}, {56'd0, e[71:64]});
        check("b_res_data", bus16.res_rdata, e[63:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  // Presents a request and returns once it has been accepted. acc_edge is the
  // index of the accepting rising edge; waits counts stalled cycles.
  task automatic drive(input bit s, input bit wr, input logic [31:0] addr,
                       input logic [3:0] nb, input logic [63:0] wd,
                       input logic [7:0] id, output int acc_edge, output int waits);
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_num_bytes = nb; req_wdata = wd; req_id = id;
    #1;
    waits = 0;
    while (stall_sel && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got stall held 200 cycles, required accept");
    end
    acc_edge = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit s);
    int n = 0;
    while (((s ? exp16_q.size() : exp4_q.size()) != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(s ? "b_drain" : "a_drain", 64'(s ? exp16_q.size() : exp4_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  nb;
    logic [63:0] wdata;
    logic [7:0]  id;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int acc, w, acc0, wsum, r0;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_id = '0; req_addr = '0;
    req_num_bytes = '0; req_wdata = '0; inj = 1'b0;
    n_rst = 1'b0;

    vecs[0]  = '{1'b1, 32'h40,   4'd8,  64'h1122334455667788, 8'h00, 64'h0};
    vecs[1]  = '{1'b0, 32'h40,   4'd0,  64'h0,                8'h2A, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 32'h80,   4'd8,  64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0};
    vecs[3]  = '{1'b1, 32'h80,   4'd3,  64'h0,                8'h00, 64'h0};
    vecs[4]  = '{1'b0, 32'h80,   4'd0,  64'h0,                8'h01, 64'hFFFFFFFFFF000000};
    vecs[5]  = '{1'b1, 32'h80,   4'd0,  64'h0,                8'h00, 64'h0};
    vecs[6]  = '{1'b0, 32'h80,   4'd0,  64'h0,                8'h02, 64'hFFFFFFFFFF000000};
    vecs[7]  = '{1'b1, 32'h80,   4'd12, 64'h0123456789ABCDEF, 8'h00, 64'h0};
    vecs[8]  = '{1'b0, 32'h80,   4'd0,  64'h0,                8'h03, 64'h0123456789ABCDEF};
    vecs[9]  = '{1'b1, 32'h100,  4'd8,  64'h0,                8'h00, 64'h0};
    vecs[10] = '{1'b1, 32'h105,  4'd1,  64'hDEADBEEFCAFEF05A, 8'h00, 64'h0};
    vecs[11] = '{1'b0, 32'h107,  4'd0,  64'h0,                8'h04, 64'h000000000000005A};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_res_valid", {63'd0, bus4.res_valid}, 64'd0);
    check("rst_res_id", {56'd0, bus4.res_id}, 64'd0);
    check("rst_res_rdata", bus4.res_rdata, 64'd0);
    check("rst_stall", {63'd0, bus4.dram_be_stall}, 64'd0);
    inj = 1'b1; #1;
    check("rst_stall_inject", {63'd0, bus4.dram_be_stall}, 64'd1);
    inj = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // table: masked writes, read-after-write, address low bits ignored
    for (int i = 0; i < 12; i++) begin
      if (!vecs[i].wr) exp4_q.push_back({vecs[i].id, vecs[i].exp});
      drive(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].nb, vecs[i].wdata, vecs[i].id, acc, w);
    end
    idle();
    wait_drain(1'b0);

    // high address bits wrap onto word 8 (byte 0x40)
    exp4_q.push_back({8'h05, 64'h1122334455667788});
    drive(1'b0, 1'b0, 32'h2040, 4'd0, 64'h0, 8'h05, acc, w);
    idle();
    wait_drain(1'b0);

    // read latency: response exactly 4 edges after the accept edge
    res4_cyc_q.delete();
    exp4_q.push_back({8'h2A, 64'h1122334455667788});
    drive(1'b0, 1'b0, 32'h40, 4'd0, 64'h0, 8'h2A, acc, w);
    idle();
    wait_drain(1'b0);
    check("a_latency", 64'(res4_cyc_q.size() > 0 ? res4_cyc_q[0] - acc : -1), 64'd4);

    // 8 back-to-back reads: never stalled, responses on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(i * 8), 4'd8, 64'hA5A5000000000000 | 64'(i), 8'h0, acc, w);
    end
    idle();
    res4_cyc_q.delete();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      exp4_q.push_back({8'(i), 64'hA5A5000000000000 | 64'(i)});
      drive(1'b0, 1'b0, 32'h200 + 32'(i * 8), 4'd0, 64'h0, 8'(i), acc, w);
      wsum += w;
    end
    idle();
    wait_drain(1'b0);
    check("a_burst_no_stall", 64'(wsum), 64'd0);
    check("a_burst_count", 64'(res4_cyc_q.size()), 64'd8);
    check("a_burst_spacing", 64'(res4_cyc_q.size() == 8 ? res4_cyc_q[7] - res4_cyc_q[0] : -1), 64'd7);

    // queue full at RD_LATENCY=16: 9th read waits for the first pop
    drive(1'b1, 1'b1, 32'h40, 4'd8, 64'hCAFEF00D12345678, 8'h0, acc, w);
    idle();
    res16_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp16_q.push_back({8'(i), 64'hCAFEF00D12345678});
      drive(1'b1, 1'b0, 32'h40, 4'd0, 64'h0, 8'(i), acc, w);
      if (i == 0) acc0 = acc;
    end
    #2;
    check("b_full_stall", {63'd0, bus16.dram_be_stall}, 64'd1);
    exp16_q.push_back({8'h08, 64'hCAFEF00D12345678});
    drive(1'b1, 1'b0, 32'h40, 4'd0, 64'h0, 8'h08, acc, w);
    idle();
    wait_drain(1'b1);
    check("b_resp_count", 64'(res16_cyc_q.size()), 64'd9);
    check("b_first_latency", 64'(res16_cyc_q.size() > 0 ? res16_cyc_q[0] - acc0 : -1), 64'd16);
    check("b_ninth_accept", 64'(res16_cyc_q.size() > 0 ? acc - res16_cyc_q[0] : -1), 64'd1);

    // stall_inject holds off a valid request until released
    sel = 1'b0;
    res4_cyc_q.delete();
    @(negedge clk);
    inj = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80; req_id = 8'h77;
    #1;
    check("a_inject_stall", {63'd0, bus4.dram_be_stall}, 64'd1);
    repeat (10) @(negedge clk);
    check("a_inject_no_resp", 64'(res4_cyc_q.size()), 64'd0);
    exp4_q.push_back({8'h77, 64'h0123456789ABCDEF});
    inj = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain(1'b0);
    check("a_inject_one_resp", 64'(res4_cyc_q.size()), 64'd1);

    // reset with reads in flight: dropped, array retained
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h80, 4'd0, 64'h0, 8'h31 + 8'(i), acc, w);
    end
    idle();
    res4_cyc_q.delete();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("mid_rst_stall", {63'd0, bus4.dram_be_stall}, 64'd0);
    check("mid_rst_res_id", {56'd0, bus4.res_id}, 64'd0);
    repeat (12) @(negedge clk);
    check("mid_rst_no_resp", 64'(res4_cyc_q.size()), 64'd0);
    exp4_q.push_back({8'h3C, 64'h1122334455667788});
    drive(1'b0, 1'b0, 32'h40, 4'd0, 64'h0, 8'h3C, acc, w);
    idle();
    wait_drain(1'b0);
    check("mid_rst_resp_count", 64'(res4_cyc_q.size()), 64'd1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
